ram_8_16_arbiter: RTL



---
 rtl/ram_8_16_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/ram_8_16_arbiter.sv
// Two-requester, single-issue controller for an 8x16 dual-port RAM with registered read data.
// Build option: define ARB_FIXED_PRI_EN for fixed priority (requester 0 first) instead of round-robin.

module ram_8_16_arbiter_ret #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              hit,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata
);
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= hit;
            if (hit) rdata <= ram_rdata;
        end
    end
endmodule

module ram_8_16_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              rw0,
    input  logic              rw1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              ram_clr,
    output logic              ram_we,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [ADDR_W-1:0] ram_rd_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    localparam int NREQ   = 2;
    localparam int STAGES = 2;

    typedef struct packed {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    typedef struct packed {
        logic vld;
        logic id;
    } rd_tag_t;

    logic [NREQ-1:0]             req, gnt, elig, win, hit, rvalid;
    req_t [NREQ-1:0]             rq;
    logic [NREQ-1:0][DATA_W-1:0] rdata;
    logic                        sel;
    req_t                        op;
    rd_tag_t                     rd_issue;
    rd_tag_t [STAGES:1]          vld_pipe;

    assign req   = {req1, req0};
    assign rq[0] = {rw0, addr0, wdata0};
    assign rq[1] = {rw1, addr1, wdata1};

    // A requester granted this cycle sits out the next edge.
    assign elig = req & ~gnt;

`ifdef ARB_FIXED_PRI_EN
    always_comb begin
        win = '0;
        if (elig[0])      win = 2'b01;
        else if (elig[1]) win = 2'b10;
    end
`else
    logic last;

    always_comb begin
        win = '0;
        case (elig)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11:   win = last ? 2'b01 : 2'b10;
            default: win = '0;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)    last <= 1'b1;
        else if (|win) last <= sel;
    end
`endif

    assign sel      = win[1];
    assign op       = rq[sel];
    assign rd_issue = '{vld: (|win) & ~op.rw, id: sel};

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            gnt         <= '0;
            ram_we      <= 1'b0;
            ram_re      <= 1'b0;
            ram_wr_addr <= '0;
            ram_rd_addr <= '0;
            ram_wdata   <= '0;
            vld_pipe    <= '0;
        end else begin
            gnt      <= win;
            ram_we   <= 1'b0;
            ram_re   <= 1'b0;
            vld_pipe <= {vld_pipe[1], rd_issue};
            // The address of the port not used this cycle keeps its old value.
            if (|win) begin
                if (op.rw) begin
                    ram_we      <= 1'b1;
                    ram_wr_addr <= op.addr;
                    ram_wdata   <= op.wdata;
                end else begin
                    ram_re      <= 1'b1;
                    ram_rd_addr <= op.addr;
                end
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NREQ; g++) begin : g_ret
            assign hit[g] = vld_pipe[STAGES].vld && (32'(vld_pipe[STAGES].id) == g);
            ram_8_16_arbiter_ret #(.DATA_W(DATA_W)) u_ret (
                .clk       (clk),
                .clr_n     (clr_n),
                .hit       (hit[g]),
                .ram_rdata (ram_rdata),
                .rvalid    (rvalid[g]),
                .rdata     (rdata[g])
            );
        end
    endgenerate

    assign ram_clr = ~clr_n;
    assign gnt0    = gnt[0];
    assign gnt1    = gnt[1];
    assign rvalid0 = rvalid[0];
    assign rvalid1 = rvalid[1];
    assign rdata0  = rdata[0];
    assign rdata1  = rdata[1];
endmodule
